// File: rtl/bcd_down_cnt3.sv
// Three-digit BCD down-counter with prescaled ticks, stop/resume and a done pulse at 000.
// Optional auto-reload on terminal count: define BCD_DOWN_CNT_RELOAD_EN.
module bcd_down_cnt3 #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld0,
  input  logic [3:0] ld1,
  input  logic [3:0] ld2,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic       busy,
  output logic       zero,
  output logic       done,
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] PSC_MAX = 16'(TICK_DIV - 1);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] rel_q, rel_d;
  logic [15:0] psc_q, psc_d;
  logic        done_q, done_d;

  logic [11:0] dec_val;
  logic [11:0] ld_sat;
  logic        cnt_zero;
  logic        dec_zero;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign ld_sat   = {sat9(ld2), sat9(ld1), sat9(ld0)};
  assign cnt_zero = (cnt_q == 12'h000);
  assign dec_zero = (dec_val == 12'h000);

  // Digit-wise borrow chain; only ever applied to a non-zero count.
  always_comb begin
    logic borrow0;
    logic borrow1;
    dec_val = cnt_q;
    borrow0 = (cnt_q[3:0] == 4'd0);
    borrow1 = borrow0 && (cnt_q[7:4] == 4'd0);
    dec_val[3:0] = borrow0 ? 4'd9 : cnt_q[3:0] - 4'd1;
    if (borrow0) begin
      dec_val[7:4] = (cnt_q[7:4] == 4'd0) ? 4'd9 : cnt_q[7:4] - 4'd1;
    end
    if (borrow1) begin
      dec_val[11:8] = (cnt_q[11:8] == 4'd0) ? 4'd9 : cnt_q[11:8] - 4'd1;
    end
  end

  // Priority each cycle: load > stop > start > tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    psc_d   = psc_q;
    done_d  = 1'b0;
    if (load) begin
      cnt_d   = ld_sat;
      rel_d   = ld_sat;
      psc_d   = 16'd0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!stop && start) begin
            if (cnt_zero) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
              psc_d   = 16'd0;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_IDLE;
            psc_d   = 16'd0;
          end else if (psc_q == PSC_MAX) begin
            psc_d = 16'd0;
            cnt_d = dec_val;
            if (dec_zero) begin
              done_d = 1'b1;
`ifdef BCD_DOWN_CNT_RELOAD_EN
              if (rel_q != 12'h000) begin
                cnt_d = rel_q;
              end else begin
                state_d = S_DONE;
              end
`else
              state_d = S_DONE;
`endif
            end
          end else begin
            psc_d = psc_q + 16'd1;
          end
        end
        S_DONE: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (start) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 12'h000;
      rel_q   <= 12'h000;
      psc_q   <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      psc_q   <= psc_d;
      done_q  <= done_d;
    end
  end

  assign out0        = cnt_q[3:0];
  assign out1        = cnt_q[7:4];
  assign out2        = cnt_q[11:8];
  assign busy        = (state_q == S_RUN);
  assign zero        = cnt_zero;
  assign done        = done_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bcd_down_cnt3.sv
// Bench for bcd_down_cnt3: two instances (TICK_DIV 1 and 4) share stimulus; each has its own
// expected queue drained by a monitor one time-step after every rising edge.
module tb_bcd_down_cnt3;

  localparam int W = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] ld0 = '0, ld1 = '0, ld2 = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;

  logic [3:0] a_o0, a_o1, a_o2, b_o0, b_o1, b_o2;
  logic       a_busy, a_zero, a_done, b_busy, b_zero, b_done;
  logic [1:0] a_st, b_st;

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp4_q[$];
  string        tag1_q[$];
  string        tag4_q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_down_cnt3 #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .reset(rst), .load(load), .ld0(ld0), .ld1(ld1), .ld2(ld2),
    .start(start), .stop(stop), .out0(a_o0), .out1(a_o1), .out2(a_o2),
    .busy(a_busy), .zero(a_zero), .done(a_done), .state_dbg_o(a_st)
  );

  bcd_down_cnt3 #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .reset(rst), .load(load), .ld0(ld0), .ld1(ld1), .ld2(ld2),
    .start(start), .stop(stop), .out0(b_o0), .out1(b_o1), .out2(b_o2),
    .busy(b_busy), .zero(b_zero), .done(b_done), .state_dbg_o(b_st)
  );

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [W-1:0] pk(input int cnt, input bit bsy, input bit dn);
    return {bcd(cnt), bsy, dn, (cnt == 0)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got cnt=%h busy=%b done=%b zero=%b, expected cnt=%h busy=%b done=%b zero=%b",
               name, act[14:3], act[2], act[1], act[0], exp[14:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the selected instance's queue.
  task automatic step(input string name, input bit sel4, input bit ld, input logic [11:0] ldv,
                      input bit st, input bit sp, input int ecnt, input bit ebusy, input bit edone);
    @(negedge clk);
    load = ld;
    {ld2, ld1, ld0} = ldv;
    start = st;
    stop = sp;
    if (sel4) begin
      exp4_q.push_back(pk(ecnt, ebusy, edone));
      tag4_q.push_back(name);
    end else begin
      exp1_q.push_back(pk(ecnt, ebusy, edone));
      tag1_q.push_back(name);
    end
    @(posedge clk);
  endtask

  task automatic idle(input string name, input bit sel4, input int ecnt, input bit ebusy, input bit edone);
    step(name, sel4, 1'b0, 12'h000, 1'b0, 1'b0, ecnt, ebusy, edone);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp1_q.size() != 0) begin
      check(tag1_q.pop_front(), {a_o2, a_o1, a_o0, a_busy, a_done, a_zero}, exp1_q.pop_front());
    end
    if (exp4_q.size() != 0) begin
      check(tag4_q.pop_front(), {b_o2, b_o1, b_o0, b_busy, b_done, b_zero}, exp4_q.pop_front());
    end
  end

  initial begin
    #3;
    check("reset_state", {a_o2, a_o1, a_o0, a_busy, a_done, a_zero}, pk(0, 0, 0));
    check("reset_state4", {b_o2, b_o1, b_o0, b_busy, b_done, b_zero}, pk(0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    // 010 counts down to 000 with one decrement per cycle.
    step("load_010", 0, 1, 12'h010, 0, 0, 10, 0, 0);
    step("start_010", 0, 0, 12'h000, 1, 0, 10, 1, 0);
    for (int k = 9; k >= 1; k--) idle("run_010", 0, k, 1, 0);
`ifdef BCD_DOWN_CNT_RELOAD_EN
    idle("reload_010", 0, 10, 1, 1);
    step("stop_reload", 0, 0, 12'h000, 0, 1, 10, 0, 0);
`else
    idle("done_010", 0, 0, 0, 1);
    idle("after_done", 0, 0, 0, 0);
`endif

    // Double borrow, stop/resume, start while running.
    step("load_100", 0, 1, 12'h100, 0, 0, 100, 0, 0);
    step("start_100", 0, 0, 12'h000, 1, 0, 100, 1, 0);
    idle("dec_099", 0, 99, 1, 0);
    idle("dec_098", 0, 98, 1, 0);
    idle("dec_097", 0, 97, 1, 0);
    step("stop_097", 0, 0, 12'h000, 0, 1, 97, 0, 0);
    idle("hold_097", 0, 97, 0, 0);
    step("resume", 0, 0, 12'h000, 1, 0, 97, 1, 0);
    idle("dec_096", 0, 96, 1, 0);
    step("start_in_run", 0, 0, 12'h000, 1, 0, 95, 1, 0);

    // Saturation, load beats start, stop beats start.
    step("load_sat", 0, 1, 12'h3AF, 0, 0, 399, 0, 0);
    step("load_start", 0, 1, 12'h060, 1, 0, 60, 0, 0);
    step("stop_start", 0, 0, 12'h000, 1, 1, 60, 0, 0);
    step("start_060", 0, 0, 12'h000, 1, 0, 60, 1, 0);
    idle("dec_059", 0, 59, 1, 0);
    idle("dec_058", 0, 58, 1, 0);
    idle("dec_057", 0, 57, 1, 0);

    // Asynchronous reset mid-count.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset", {a_o2, a_o1, a_o0, a_busy, a_done, a_zero}, pk(0, 0, 0));
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_hold", {a_o2, a_o1, a_o0, a_busy, a_done, a_zero}, pk(0, 0, 0));
    end
    @(negedge clk);
    rst = 1'b0;

    // Start at 000: single done pulse, no wrap.
    step("start_zero", 0, 0, 12'h000, 1, 0, 0, 0, 1);
    idle("zero_idle", 0, 0, 0, 0);
    idle("zero_idle2", 0, 0, 0, 0);

    // TICK_DIV=4: decrements four cycles apart.
    step("t4_load_002", 1, 1, 12'h002, 0, 0, 2, 0, 0);
    step("t4_start", 1, 0, 12'h000, 1, 0, 2, 1, 0);
    for (int k = 1; k <= 3; k++) idle("t4_wait_a", 1, 2, 1, 0);
    for (int k = 1; k <= 4; k++) idle("t4_wait_b", 1, 1, 1, 0);
`ifdef BCD_DOWN_CNT_RELOAD_EN
    idle("t4_reload", 1, 2, 1, 1);
    step("t4_stop", 1, 0, 12'h000, 0, 1, 2, 0, 0);

    // Continuous reload of 003 keeps busy high.
    step("rl_load_003", 0, 1, 12'h003, 0, 0, 3, 0, 0);
    step("rl_start", 0, 0, 12'h000, 1, 0, 3, 1, 0);
    repeat (2) begin
      idle("rl_dec_2", 0, 2, 1, 0);
      idle("rl_dec_1", 0, 1, 1, 0);
      idle("rl_wrap", 0, 3, 1, 1);
    end
    step("rl_stop", 0, 0, 12'h000, 0, 1, 3, 0, 0);
`else
    idle("t4_done", 1, 0, 0, 1);
    idle("t4_after", 1, 0, 0, 0);
`endif

    begin
      int guard;
      guard = 0;
      while ((exp1_q.size() != 0 || exp4_q.size() != 0) && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (exp1_q.size() != 0 || exp4_q.size() != 0) begin
        n_vec++;
        n_err++;
        $display("FAIL drain: %0d/%0d entries left, expected 0", exp1_q.size(), exp4_q.size());
      end
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
